// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: FSM state type and default program-counter width shared by the fetch logic.
package pc_fetch_pkg;
    localparam int PC_W = 12;
    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
endpackage

// File: rtl/pc_fetch.sv
// pc_fetch: program-counter sequencer with start/stall/branch/halt control and a saturating RUN-cycle counter.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter int D        = PC_W,
    parameter int START_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [D-1:0]     target,
    input  logic             halt,
    output logic [D-1:0]     prog_counter,
    output logic             fetch_en,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count
);
    state_t           state, state_n;
    logic [D-1:0]     pc_n;
    logic [CNT_W-1:0] cnt_n;
    logic [D-1:0]     branch_pc;

    // Offset is sign-extended one bit past D; truncation back to D gives the silent wrap.
    assign branch_pc = D'({1'b0, prog_counter} + {target[D-1], target});
    assign fetch_en  = state == RUN;
    assign done      = state == HALTED;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            prog_counter <= '0;
            cycle_count  <= '0;
        end else begin
            state        <= state_n;
            prog_counter <= pc_n;
            cycle_count  <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = prog_counter;
        cnt_n   = cycle_count;
        if (state == IDLE && start) begin
            state_n = RUN;
            pc_n    = D'(START_PC);
            cnt_n   = '0;
        end else if (state == RUN) begin
            cnt_n = &cycle_count ? cycle_count : cycle_count + CNT_W'(1);
            if (!stall && halt)
                state_n = HALTED;
            else if (!stall)
                pc_n = branch_taken ? branch_pc : prog_counter + D'(1);
        end else if (state == HALTED) begin
            state_n = IDLE;
        end
    end
endmodule
